// File: rtl/rcc_rtc_div_pkg.sv
// Shared types and constants for the RTC divider ratio-change controller.
// Holds the FSM state encoding, the wait-counter width and the default ratio width.
// Imported by rcc_rtc_div_ctrl and rcc_rtc_div_wait_cnt.
package rcc_rtc_div_pkg;

    localparam int CNT_WID       = 8;
    localparam int RATIO_WID_DEF = 6;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GATE   = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_OPEN   = 3'd4,
        ST_ACK    = 3'd5
    } state_e;

endpackage

// File: rtl/rcc_rtc_div_wait_cnt.sv
// Purpose: 8-bit load/down-count wait timer shared by the GATE and SETTLE states.
// Latency: zero reflects the registered count; a load of N gives zero after N enabled cycles.
// Backpressure: none; stops at zero and never wraps.
// Ports: i_clk, rst_n, load (takes priority), load_val, en (decrement), zero (count == 0).
module rcc_rtc_div_wait_cnt
    import rcc_rtc_div_pkg::*;
(
    input  logic               i_clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [CNT_WID-1:0] load_val,
    input  logic               en,
    output logic               zero
);

    logic [CNT_WID-1:0] cnt;

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/rcc_rtc_div_ctrl.sv
// Purpose: sequences a glitch-free RTC divider ratio change (close gate, load, settle, reopen, ack).
// Latency: ack pulses GATE_CYC+SETTLE_CYC+3 cycles after the req-capture edge (2 on a same-ratio skip).
// Backpressure: req is a level handshake; it is ignored while busy and in the cycle ack is high.
// Ports: i_clk, rst_n, req, new_ratio -> ack, busy, ratio_o, gate_en (all outputs registered).
// Build option: RCC_RTC_DIV_CTRL_SAME_SKIP_EN skips the gate/load/settle sequence when
// new_ratio already equals ratio_o.
module rcc_rtc_div_ctrl
    import rcc_rtc_div_pkg::*;
#(
    parameter int RATIO_WID  = RATIO_WID_DEF,
    parameter int GATE_CYC   = 4,
    parameter int SETTLE_CYC = 8
) (
    input  logic                 i_clk,
    input  logic                 rst_n,
    input  logic                 req,
    input  logic [RATIO_WID-1:0] new_ratio,
    output logic                 ack,
    output logic                 busy,
    output logic [RATIO_WID-1:0] ratio_o,
    output logic                 gate_en
);

    localparam logic [CNT_WID-1:0] GATE_LD   = CNT_WID'(GATE_CYC - 1);
    localparam logic [CNT_WID-1:0] SETTLE_LD = CNT_WID'(SETTLE_CYC - 1);

    state_e               state;
    state_e               state_nxt;
    logic [RATIO_WID-1:0] pending;
    logic                 capture;
    logic                 same_ratio;
    logic                 cnt_load;
    logic [CNT_WID-1:0]   cnt_load_val;
    logic                 cnt_en;
    logic                 cnt_zero;

    // ack is high in the first IDLE cycle after ACK; blocking capture there keeps a
    // requester that is slow to drop req from being serviced twice.
    assign capture = (state == ST_IDLE) && req && !ack;

`ifdef RCC_RTC_DIV_CTRL_SAME_SKIP_EN
    assign same_ratio = (new_ratio == ratio_o);
`else
    assign same_ratio = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        cnt_load     = 1'b0;
        cnt_load_val = GATE_LD;
        cnt_en       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (capture) begin
                    if (same_ratio) begin
                        // OPEN is used as a one-cycle pad so ack lands two cycles after
                        // capture; gate_en is already 1, so nothing visible changes.
                        state_nxt = ST_OPEN;
                    end else begin
                        state_nxt    = ST_GATE;
                        cnt_load     = 1'b1;
                        cnt_load_val = GATE_LD;
                    end
                end
            end
            ST_GATE: begin
                if (cnt_zero) begin
                    state_nxt = ST_LOAD;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_LOAD: begin
                state_nxt    = ST_SETTLE;
                cnt_load     = 1'b1;
                cnt_load_val = SETTLE_LD;
            end
            ST_SETTLE: begin
                if (cnt_zero) begin
                    state_nxt = ST_OPEN;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_OPEN:  state_nxt = ST_ACK;
            ST_ACK:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    rcc_rtc_div_wait_cnt u_wait_cnt (
        .i_clk    (i_clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    // Outputs are registered from the current state, so each one changes on the edge
    // that leaves the state driving it (gate closes on GATE's first edge, ratio updates
    // on LOAD's edge, gate reopens on OPEN's edge, ack follows ACK by one edge).
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pending <= '0;
            busy    <= 1'b0;
            ack     <= 1'b0;
            gate_en <= 1'b1;
            ratio_o <= '0;
        end else begin
            state <= state_nxt;
            ack   <= (state == ST_ACK);
            if (capture) begin
                pending <= new_ratio;
            end
            if (capture) begin
                busy <= 1'b1;
            end else if (state == ST_ACK) begin
                busy <= 1'b0;
            end
            if (state == ST_GATE) begin
                gate_en <= 1'b0;
            end else if (state == ST_OPEN) begin
                gate_en <= 1'b1;
            end
            if (state == ST_LOAD) begin
                ratio_o <= pending;
            end
        end
    end

endmodule

// File: tb/tb_rcc_rtc_div_ctrl.sv
// Purpose: directed self-checking bench for rcc_rtc_div_ctrl (default and 1/1 timing builds).
// Latency: expected cycle counts are hand-derived from the capture edge (edge 0).
// Backpressure: requester holds req until ack, except where a test deliberately holds it longer.
module tb_rcc_rtc_div_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       req = 1'b0;
    logic [5:0] new_ratio = '0;
    logic       ack;
    logic       busy;
    logic [5:0] ratio_o;
    logic       gate_en;

    logic       f_req = 1'b0;
    logic [5:0] f_ratio = '0;
    logic       f_ack;
    logic       f_busy;
    logic [5:0] f_ratio_o;
    logic       f_gate_en;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    rcc_rtc_div_ctrl dut (
        .i_clk     (clk),
        .rst_n     (rst_n),
        .req       (req),
        .new_ratio (new_ratio),
        .ack       (ack),
        .busy      (busy),
        .ratio_o   (ratio_o),
        .gate_en   (gate_en)
    );

    rcc_rtc_div_ctrl #(.RATIO_WID(6), .GATE_CYC(1), .SETTLE_CYC(1)) dut_fast (
        .i_clk     (clk),
        .rst_n     (rst_n),
        .req       (f_req),
        .new_ratio (f_ratio),
        .ack       (f_ack),
        .busy      (f_busy),
        .ratio_o   (f_ratio_o),
        .gate_en   (f_gate_en)
    );

    // Drives one request on the default instance and records when ack appears,
    // counted in edges after the capture edge (edge 0). No checking here.
    task automatic run_req(input logic [5:0] r, input int max_cyc,
                           output int ack_cyc, output bit gate_low, output int ack_cnt);
        req      = 1'b1;
        new_ratio = r;
        ack_cyc  = -1;
        gate_low = 1'b0;
        ack_cnt  = 0;
        for (int n = 0; n < max_cyc; n++) begin
            @(posedge clk); #1;
            if (!gate_en) gate_low = 1'b1;
            if (ack) begin
                ack_cnt++;
                if (ack_cyc < 0) ack_cyc = n;
                req = 1'b0;
            end
        end
        req = 1'b0;
    endtask

    task automatic do_reset();
        req = 1'b0;
        f_req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        obs = {ratio_o, gate_en, ack, busy};
        if (obs !== {6'd0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_in_reset: got %h want %h", obs, {6'd0, 1'b1, 1'b0, 1'b0});
        end
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            vectors++;
            obs = {ratio_o, gate_en, ack, busy};
            if (obs !== {6'd0, 1'b1, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL reset_idle cyc %0d: got %h want %h", n, obs, {6'd0, 1'b1, 1'b0, 1'b0});
            end
        end
        vectors++;
        obs = {f_ratio_o, f_gate_en, f_ack, f_busy};
        if (obs !== {6'd0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_fast: got %h want %h", obs, {6'd0, 1'b1, 1'b0, 1'b0});
        end
    endtask

    task automatic test_basic_seq();
        logic [8:0] obs;
        logic [8:0] expv;
        req = 1'b1;
        new_ratio = 6'd5;
        for (int n = 0; n <= 16; n++) begin
            @(posedge clk); #1;
            expv[8:3] = (n >= 5) ? 6'd5 : 6'd0;
            expv[2]   = !(n >= 1 && n <= 13);
            expv[1]   = (n == 15);
            expv[0]   = (n <= 14);
            obs = {ratio_o, gate_en, ack, busy};
            vectors++;
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL basic cyc %0d: got {ratio,gate,ack,busy}=%h want %h", n, obs, expv);
            end
            if (ack) req = 1'b0;
        end
        req = 1'b0;
    endtask

    task automatic test_slow_drop();
        int ack_cyc;
        req = 1'b1;
        new_ratio = 6'd12;
        ack_cyc = -1;
        for (int n = 0; n < 20 && ack_cyc < 0; n++) begin
            @(posedge clk); #1;
            if (ack) ack_cyc = n;
        end
        vectors++;
        if (ack_cyc != 15) begin
            miscompares++;
            $display("FAIL slow_drop_ack: got cycle %0d want 15", ack_cyc);
        end
        // req stays high through the ack cycle and one more edge
        @(posedge clk); #1;
        vectors++;
        if ({busy, ack} !== 2'b00) begin
            miscompares++;
            $display("FAIL slow_drop_recapture: got busy,ack=%b want 00", {busy, ack});
        end
        req = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({busy, ratio_o} !== {1'b0, 6'd12}) begin
            miscompares++;
            $display("FAIL slow_drop_final: got busy=%b ratio=%0d want 0/12", busy, ratio_o);
        end
    endtask

    task automatic test_busy_ignore();
        int ack_cnt;
        int ack_cyc;
        do_reset();
        req = 1'b1;
        new_ratio = 6'd5;
        ack_cnt = 0;
        ack_cyc = -1;
        for (int n = 0; n < 25; n++) begin
            @(posedge clk); #1;
            if (ack) begin
                ack_cnt++;
                if (ack_cyc < 0) ack_cyc = n;
                req = 1'b0;
            end else if (ack_cyc < 0) begin
                if (n == 1) new_ratio = 6'd9;
                if (n == 3 || n == 8) req = 1'b0;
                if (n == 4 || n == 9) req = 1'b1;
            end
        end
        req = 1'b0;
        vectors++;
        if (ack_cnt != 1 || ack_cyc != 15) begin
            miscompares++;
            $display("FAIL busy_ignore_ack: got %0d acks first at %0d want 1 at 15", ack_cnt, ack_cyc);
        end
        vectors++;
        if (ratio_o !== 6'd5) begin
            miscompares++;
            $display("FAIL busy_ignore_ratio: got %0d want 5", ratio_o);
        end
    endtask

    task automatic test_reset_mid();
        int ack_cnt;
        req = 1'b1;
        new_ratio = 6'd9;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
        end
        vectors++;
        if ({gate_en, busy} !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_mid_pre: got gate,busy=%b want 01", {gate_en, busy});
        end
        #1 rst_n = 1'b0;
        #1;
        vectors++;
        if ({ratio_o, gate_en, ack, busy} !== {6'd0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_mid_async: got %h want %h",
                     {ratio_o, gate_en, ack, busy}, {6'd0, 1'b1, 1'b0, 1'b0});
        end
        req = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        ack_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (ack || busy) ack_cnt++;
        end
        vectors++;
        if (ack_cnt != 0 || ratio_o !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_mid_after: got %0d ack/busy cycles ratio=%0d want 0 and 0", ack_cnt, ratio_o);
        end
    endtask

    task automatic test_same_ratio();
        int  ack_cyc;
        int  ack_cnt;
        bit  gate_low;
        int  exp_cyc;
        bit  exp_low;
        run_req(6'd5, 20, ack_cyc, gate_low, ack_cnt);
        vectors++;
        if (ack_cyc != 15 || !gate_low || ratio_o !== 6'd5) begin
            miscompares++;
            $display("FAIL same_first: got ack %0d gate_low %0b ratio %0d want 15/1/5",
                     ack_cyc, gate_low, ratio_o);
        end
`ifdef RCC_RTC_DIV_CTRL_SAME_SKIP_EN
        exp_cyc = 2;
        exp_low = 1'b0;
`else
        exp_cyc = 15;
        exp_low = 1'b1;
`endif
        run_req(6'd5, 20, ack_cyc, gate_low, ack_cnt);
        vectors++;
        if (ack_cyc != exp_cyc || gate_low != exp_low || ack_cnt != 1 || ratio_o !== 6'd5) begin
            miscompares++;
            $display("FAIL same_second: got ack %0d gate_low %0b acks %0d ratio %0d want %0d/%0b/1/5",
                     ack_cyc, gate_low, ack_cnt, ratio_o, exp_cyc, exp_low);
        end
    endtask

    task automatic test_back_to_back();
        int ack_cyc;
        int exp0;
        bit gate_low;
`ifdef RCC_RTC_DIV_CTRL_SAME_SKIP_EN
        exp0 = 2;   // ratio 0 already active after reset
`else
        exp0 = 5;
`endif
        do_reset();
        f_req = 1'b1;
        f_ratio = 6'd0;
        ack_cyc = -1;
        for (int n = 0; n < 10 && ack_cyc < 0; n++) begin
            @(posedge clk); #1;
            if (f_ack) begin
                ack_cyc = n;
                f_req = 1'b0;
            end
        end
        vectors++;
        if (ack_cyc != exp0 || f_ratio_o !== 6'd0 || f_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_first: got ack %0d ratio %0d busy %b want %0d/0/0",
                     ack_cyc, f_ratio_o, f_busy, exp0);
        end
        @(posedge clk); #1;
        f_req = 1'b1;
        f_ratio = 6'd63;
        ack_cyc = -1;
        gate_low = 1'b0;
        for (int n = 0; n < 10 && ack_cyc < 0; n++) begin
            @(posedge clk); #1;
            if (!f_gate_en) gate_low = 1'b1;
            if (f_ack) begin
                ack_cyc = n;
                f_req = 1'b0;
            end
        end
        vectors++;
        if (ack_cyc != 5 || f_ratio_o !== 6'd63 || !gate_low || f_gate_en !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second: got ack %0d ratio %0d gate_low %0b gate %b want 5/63/1/1",
                     ack_cyc, f_ratio_o, gate_low, f_gate_en);
        end
        f_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_seq();
        test_slow_drop();
        test_busy_ignore();
        test_reset_mid();
        test_same_ratio();
        test_back_to_back();
        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rcc_rtc_div_ctrl.md
RCC_RTC_DIV_CTRL -- requirements
Module: rcc_rtc_div_ctrl

Interface
REQ-001 SHALL have parameter RATIO_WID, default 6, width of the divide ratio.
REQ-002 SHALL have parameter GATE_CYC, default 4, i_clk cycles the output gate is held closed before a ratio load (range 1..255).
REQ-003 SHALL have parameter SETTLE_CYC, default 8, i_clk cycles waited after a ratio load before reopening the gate (range 1..255; shall cover 2 synchroniser stages plus one full divided period).
REQ-004 SHALL have port i_clk  input  1  single clock of the block.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port req  input  1  ratio-change request, level; held high until ack is seen.
REQ-007 SHALL have port new_ratio  input  RATIO_WID  requested ratio, valid while req is high.
REQ-008 SHALL have port ack  output  1  one-cycle pulse: the requested ratio is active and the gate is open.
REQ-009 SHALL have port busy  output  1  high from request capture until ack.
REQ-010 SHALL have port ratio_o  output  RATIO_WID  ratio driven to the divider.
REQ-011 SHALL have port gate_en  output  1  enable for the divided-clock gate; 1 means the clock passes.

Function
REQ-012 SHALL implement the FSM states IDLE, GATE, LOAD, SETTLE, OPEN and ACK.
REQ-013 In IDLE with req=1, SHALL capture new_ratio into a pending register, set busy, and enter GATE on the next edge.
REQ-014 SHALL drive gate_en=0 on entry to GATE and hold GATE for exactly GATE_CYC cycles.
REQ-015 LOAD SHALL last one cycle and update ratio_o from the pending register on that cycle's edge.
REQ-016 SHALL hold SETTLE for exactly SETTLE_CYC cycles, keeping ratio_o stable and gate_en=0.
REQ-017 OPEN SHALL set gate_en=1 and last one cycle; ACK SHALL pulse ack=1 for one cycle, clear busy, and return to IDLE.
REQ-018 Latency from the req-capture edge to the ack pulse SHALL be GATE_CYC+SETTLE_CYC+3 cycles.
REQ-019 SHALL ignore req and new_ratio changes while busy=1.
REQ-020 SHALL NOT capture req in the cycle immediately after ACK, so a requester that is slow to drop req is not re-serviced.
REQ-021 SHALL NOT filter new_ratio values 0 and 1: they are loaded normally, and divider bypass is handled downstream.
REQ-022 SHALL keep ratio_o and gate_en glitch-free: both are registered outputs, with no combinational path from inputs.
REQ-023 Wait counters SHALL be 8 bits, load GATE_CYC-1 or SETTLE_CYC-1, count down, and exit the state at zero; they shall never wrap.

Reset
REQ-024 On rst_n=0, SHALL asynchronously set state=IDLE, ratio_o=0, gate_en=1, ack=0, busy=0 and counters=0.
REQ-025 Reset asserted mid-sequence SHALL abort the sequence with no ack; the pending ratio is discarded.
REQ-026 Reset deassertion SHALL be synchronised externally; the block assumes a clean release.

Configuration
REQ-027 Macro RCC_RTC_DIV_CTRL_SAME_SKIP_EN defined: in IDLE, a req whose new_ratio equals ratio_o SHALL skip GATE, LOAD, SETTLE and OPEN and pulse ack 2 cycles after capture, with gate_en staying 1.
REQ-028 Macro RCC_RTC_DIV_CTRL_SAME_SKIP_EN undefined: every request SHALL run the full sequence of REQ-018.

Structure
REQ-029 Package rcc_rtc_div_pkg SHALL hold the FSM state enum, the counter width constant (8), and the default RATIO_WID.
REQ-030 The down-counter SHALL be the sub-module rcc_rtc_div_wait_cnt (inputs load, load_val, en; output zero), instantiated once and shared by GATE and SETTLE.

Verification
REQ-031 Reset then idle: ratio_o=0, gate_en=1, ack=0, busy=0 held for 20 cycles.
REQ-032 Defaults, req with new_ratio=5: gate_en falls 1 cycle after capture, ratio_o=5 after 5 cycles, gate_en=1 at cycle 14, ack pulse at cycle 15.
REQ-033 During busy, change new_ratio to 9 and toggle req: the final ratio_o is still 5, and exactly one ack pulse occurs.
REQ-034 Assert rst_n=0 in SETTLE: outputs return to reset values immediately, and no ack occurs after release.
REQ-035 With SAME_SKIP_EN, req new_ratio=5 when ratio_o=5: ack at capture+2, and gate_en never goes low; without the macro, the full 15-cycle sequence runs.
REQ-036 With GATE_CYC=1 and SETTLE_CYC=1, req ratio=0 then ratio=63 back-to-back: acks 5 cycles after each capture, and ratio_o follows 0 then 63.
